// File: rtl/div_avg_pkg.sv
// Shared constants and helpers for the multi-channel averaging divider.
package div_avg_pkg;

  // Reciprocal fractional shift the R constants below are scaled for
  localparam int SH = 20;

  // Width of a reciprocal constant (R1 = 2^20 needs 21 bits)
  localparam int RW = 21;

  // Reciprocals of the kernel areas 1, 9, 25 and 49, scaled by 2^SH
  localparam logic [RW-1:0] R1 = 21'd1048576;
  localparam logic [RW-1:0] R3 = 21'd116508;
  localparam logic [RW-1:0] R5 = 21'd41943;
  localparam logic [RW-1:0] R7 = 21'd21400;

  // Kernel size select encoding
  localparam logic [1:0] KSZ_1 = 2'b00;
  localparam logic [1:0] KSZ_3 = 2'b01;
  localparam logic [1:0] KSZ_5 = 2'b10;
  localparam logic [1:0] KSZ_7 = 2'b11;

  // Map a kernel select code to its scaled reciprocal
  function automatic logic [RW-1:0] f_recip(input logic [1:0] ksz_sel);
    logic [RW-1:0] r;
    case (ksz_sel)
      KSZ_1:   r = R1;
      KSZ_3:   r = R3;
      KSZ_5:   r = R5;
      default: r = R7;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/div_avg_lane.sv
// One channel of the averaging divider: multiply by the reciprocal,
// round to nearest, then clamp to the output width.
module div_avg_lane
  import div_avg_pkg::*;
#(
  parameter int SW = 16,
  parameter int DW = 8,
  parameter int SH = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [SW-1:0] din,
  input  logic [RW-1:0] recip,
  input  logic          valid,
  output logic [DW-1:0] dout,
  output logic          sat
);

  localparam int PW = SW + RW;
  localparam int QW = PW - SH + 1;
  localparam logic [QW-1:0] MAXV = QW'((1 << DW) - 1);
  localparam logic [PW:0] HALF = (PW + 1)'(1) << (SH - 1);

  logic [PW-1:0] prod;
  logic [PW:0]   rounded;
  logic [QW-1:0] quot;
  logic          over;

  // Second stage: full-precision product of the sum and the reciprocal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) prod <= '0;
    else     prod <= din * recip;
  end

  // Add one half LSB of the quotient and drop the fraction bits
  always_comb begin
    rounded = {1'b0, prod} + HALF;
    quot    = rounded[PW:SH];
    over    = (quot > MAXV);
  end

  // Third stage: clamp and zero the result outside active line beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
      sat  <= 1'b0;
    end else begin
      dout <= !valid ? '0 : (over ? '1 : quot[DW-1:0]);
      sat  <= valid & over;
    end
  end

endmodule

// File: rtl/div_avg_mc.sv
// Multi-channel averaging divider placed after the 2-D window summer.
// Divides each packed window sum by the per-frame kernel area with
// rounding and saturation; syncs are delayed to match the 3-cycle pipe.
module div_avg_mc
  import div_avg_pkg::*;
#(
  parameter int CH = 3,
  parameter int SW = 16,
  parameter int DW = 8,
  parameter int SH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ksz_sel,
  input  logic             din_vsync,
  input  logic             din_hsync,
  input  logic [CH*SW-1:0] din,
  output logic             dout_vsync,
  output logic             dout_hsync,
  output logic [CH*DW-1:0] dout,
  output logic             dout_ovf,
  output logic             frame_ovf
);

  logic             vsync_s1, hsync_s1;
  logic             vsync_s2, hsync_s2;
  logic [CH*SW-1:0] din_s1;
  logic [RW-1:0]    recip_s1;
  logic [1:0]       ksz_act;
  logic             vsync_rise;
  logic             dout_vsync_d;
  logic             out_vsync_rise;
  logic [CH-1:0]    sat;

  assign vsync_rise     = din_vsync & ~vsync_s1;
  assign out_vsync_rise = dout_vsync & ~dout_vsync_d;
  assign dout_ovf       = |sat;

  // First stage: capture inputs and latch the kernel at each frame start;
  // a beat coinciding with the frame start already uses the new kernel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_s1 <= 1'b0;
      hsync_s1 <= 1'b0;
      din_s1   <= '0;
      ksz_act  <= KSZ_3;
      recip_s1 <= R3;
    end else begin
      vsync_s1 <= din_vsync;
      hsync_s1 <= din_hsync;
      din_s1   <= din;
      if (vsync_rise) begin
        ksz_act  <= ksz_sel;
        recip_s1 <= f_recip(ksz_sel);
      end else begin
        recip_s1 <= f_recip(ksz_act);
      end
    end
  end

  // Carry the syncs alongside the second and third lane stages
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_s2     <= 1'b0;
      hsync_s2     <= 1'b0;
      dout_vsync   <= 1'b0;
      dout_hsync   <= 1'b0;
      dout_vsync_d <= 1'b0;
    end else begin
      vsync_s2     <= vsync_s1;
      hsync_s2     <= hsync_s1;
      dout_vsync   <= vsync_s2;
      dout_hsync   <= hsync_s2;
      dout_vsync_d <= dout_vsync;
    end
  end

  // Sticky per-frame overflow; a saturated beat wins over the frame clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 frame_ovf <= 1'b0;
    else if (dout_ovf)       frame_ovf <= 1'b1;
    else if (out_vsync_rise) frame_ovf <= 1'b0;
  end

  for (genvar g = 0; g < CH; g++) begin : g_lane
    div_avg_lane #(
      .SW(SW),
      .DW(DW),
      .SH(SH)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .din  (din_s1[g*SW +: SW]),
      .recip(recip_s1),
      .valid(hsync_s2),
      .dout (dout[g*DW +: DW]),
      .sat  (sat[g])
    );
  end

endmodule

// File: tb/tb_div_avg_mc.sv
// Scoreboard bench for the multi-channel averaging divider.
`timescale 1ns/1ps
module tb_div_avg_mc;

  localparam int CH = 3;
  localparam int SW = 16;
  localparam int DW = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       ksz_sel;
  logic             din_vsync;
  logic             din_hsync;
  logic [CH*SW-1:0] din;
  logic             dout_vsync;
  logic             dout_hsync;
  logic [CH*DW-1:0] dout;
  logic             dout_ovf;
  logic             frame_ovf;

  typedef struct packed {
    logic [CH*DW-1:0] d;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  logic [2:0] hs_hist = 3'b0;
  logic [2:0] vs_hist = 3'b0;

  div_avg_mc #(.CH(CH), .SW(SW), .DW(DW), .SH(20)) dut (
    .clk       (clk),
    .rst       (rst),
    .ksz_sel   (ksz_sel),
    .din_vsync (din_vsync),
    .din_hsync (din_hsync),
    .din       (din),
    .dout_vsync(dout_vsync),
    .dout_hsync(dout_hsync),
    .dout      (dout),
    .dout_ovf  (dout_ovf),
    .frame_ovf (frame_ovf)
  );

  always #5 clk = ~clk;

  // Record the syncs the DUT sampled on each rising edge
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      hs_hist = 3'b0;
      vs_hist = 3'b0;
    end else begin
      hs_hist = {hs_hist[1:0], din_hsync};
      vs_hist = {vs_hist[1:0], din_vsync};
    end
  end

  // Output monitor: sync delay, scoreboard pops and gating between lines
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      total++;
      if (dout_hsync !== hs_hist[2]) begin
        bad++;
        $display("[TB] FAIL hsync_delay got=%0b want=%0b", dout_hsync, hs_hist[2]);
      end
      total++;
      if (dout_vsync !== vs_hist[2]) begin
        bad++;
        $display("[TB] FAIL vsync_delay got=%0b want=%0b", dout_vsync, vs_hist[2]);
      end
      if (dout_hsync === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("[TB] FAIL unexpected_beat got dout=%h want none", dout);
        end else begin
          mon_e = sb.pop_front();
          if (dout !== mon_e.d) begin
            bad++;
            $display("[TB] FAIL dout got=%h want=%h", dout, mon_e.d);
          end
          total++;
          if (dout_ovf !== mon_e.ovf) begin
            bad++;
            $display("[TB] FAIL dout_ovf got=%0b want=%0b", dout_ovf, mon_e.ovf);
          end
        end
      end else begin
        total++;
        if (dout !== '0 || dout_ovf !== 1'b0) begin
          bad++;
          $display("[TB] FAIL gating got dout=%h ovf=%0b want 0/0", dout, dout_ovf);
        end
      end
    end
  end

  task automatic drive(input logic vs, input logic hs, input logic [1:0] ks,
                       input logic [SW-1:0] c0, input logic [SW-1:0] c1,
                       input logic [SW-1:0] c2, input logic [DW-1:0] e0,
                       input logic [DW-1:0] e1, input logic [DW-1:0] e2,
                       input logic eovf);
    exp_t t;
    @(negedge clk);
    din_vsync = vs;
    din_hsync = hs;
    ksz_sel   = ks;
    din       = {c2, c1, c0};
    if (hs) begin
      t.d   = {e2, e1, e0};
      t.ovf = eovf;
      sb.push_back(t);
    end
  endtask

  task automatic beat(input logic vs, input logic [1:0] ks,
                      input logic [SW-1:0] c0, input logic [DW-1:0] e0);
    drive(vs, 1'b1, ks, c0, 16'd0, 16'd0, e0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic idle(input logic vs, input logic [1:0] ks, input int n);
    for (int i = 0; i < n; i++)
      drive(vs, 1'b0, ks, 16'd0, 16'd0, 16'd0, 8'd0, 8'd0, 8'd0, 1'b0);
  endtask

  task automatic drain(input logic vs, input logic [1:0] ks);
    int waited = 0;
    while (sb.size() != 0 && waited < 30) begin
      idle(vs, ks, 1);
      waited++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain left=%0d want 0", sb.size());
      sb.delete();
    end
    idle(vs, ks, 2);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_vsync = 1'b0;
    din_hsync = 1'b0;
    ksz_sel = 2'b01;
    din = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (dout !== '0) begin bad++; $display("[TB] FAIL reset_dout got=%h want 0", dout); end
    total++;
    if (dout_hsync !== 1'b0 || dout_vsync !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_sync got=%0b%0b want 00", dout_vsync, dout_hsync);
    end
    total++;
    if (dout_ovf !== 1'b0 || frame_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%0b%0b want 00", dout_ovf, frame_ovf);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_k3_lines();
    idle(1'b0, 2'b01, 2);
    beat(1'b1, 2'b01, 16'd10, 8'd1);
    beat(1'b1, 2'b01, 16'd28, 8'd3);
    beat(1'b1, 2'b01, 16'd37, 8'd4);
    beat(1'b1, 2'b01, 16'd410, 8'd46);
    idle(1'b1, 2'b01, 3);
    beat(1'b1, 2'b01, 16'd46, 8'd5);
    beat(1'b1, 2'b01, 16'd255, 8'd28);
    beat(1'b1, 2'b01, 16'd630, 8'd70);
    beat(1'b1, 2'b01, 16'd323, 8'd36);
    drain(1'b1, 2'b01);
  endtask

  task automatic test_k5_k7();
    idle(1'b0, 2'b10, 2);
    beat(1'b1, 2'b10, 16'd37, 8'd1);
    beat(1'b1, 2'b10, 16'd323, 8'd13);
    beat(1'b1, 2'b10, 16'd6375, 8'd255);
    drain(1'b1, 2'b10);
    idle(1'b0, 2'b11, 2);
    beat(1'b1, 2'b11, 16'd630, 8'd13);
    beat(1'b1, 2'b11, 16'd12495, 8'd255);
    drain(1'b1, 2'b11);
  endtask

  task automatic test_saturation();
    idle(1'b0, 2'b01, 2);
    idle(1'b1, 2'b01, 1);
    total++;
    if (frame_ovf !== 1'b0) begin bad++; $display("[TB] FAIL frame_ovf_pre got=%0b want 0", frame_ovf); end
    drive(1'b1, 1'b1, 2'b01, 16'd2295, 16'd65535, 16'd0, 8'd255, 8'd255, 8'd0, 1'b1);
    beat(1'b1, 2'b01, 16'd10, 8'd1);
    drain(1'b1, 2'b01);
    idle(1'b1, 2'b01, 3);
    total++;
    if (frame_ovf !== 1'b1) begin bad++; $display("[TB] FAIL frame_ovf_set got=%0b want 1", frame_ovf); end
    idle(1'b0, 2'b01, 2);
    idle(1'b1, 2'b01, 6);
    total++;
    if (frame_ovf !== 1'b0) begin bad++; $display("[TB] FAIL frame_ovf_clear got=%0b want 0", frame_ovf); end
  endtask

  task automatic test_midframe_toggle();
    idle(1'b0, 2'b01, 2);
    beat(1'b1, 2'b01, 16'd630, 8'd70);
    beat(1'b1, 2'b11, 16'd630, 8'd70);
    beat(1'b1, 2'b11, 16'd410, 8'd46);
    drain(1'b1, 2'b11);
    idle(1'b0, 2'b11, 2);
    beat(1'b1, 2'b11, 16'd630, 8'd13);
    drain(1'b1, 2'b11);
  endtask

  task automatic test_bypass();
    idle(1'b0, 2'b00, 2);
    beat(1'b1, 2'b00, 16'd200, 8'd200);
    drive(1'b1, 1'b1, 2'b00, 16'd300, 16'd0, 16'd0, 8'd255, 8'd0, 8'd0, 1'b1);
    drain(1'b1, 2'b00);
  endtask

  task automatic test_reset_midframe();
    mon_en = 1'b0;
    idle(1'b0, 2'b11, 2);
    beat(1'b1, 2'b11, 16'd630, 8'd13);
    beat(1'b1, 2'b11, 16'd630, 8'd13);
    beat(1'b1, 2'b11, 16'd630, 8'd13);
    @(posedge clk);
    #2;
    total++;
    if (dout_hsync !== 1'b1 || dout[DW-1:0] !== 8'd13) begin
      bad++;
      $display("[TB] FAIL pre_reset_beat got hs=%0b d=%0d want 1/13", dout_hsync, dout[DW-1:0]);
    end
    rst = 1'b1;
    #1;
    total++;
    if (dout !== '0 || dout_hsync !== 1'b0 || dout_vsync !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_out got d=%h hs=%0b vs=%0b want 0", dout, dout_hsync, dout_vsync);
    end
    total++;
    if (dout_ovf !== 1'b0 || frame_ovf !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_flags got=%0b%0b want 00", dout_ovf, frame_ovf);
    end
    din_vsync = 1'b0;
    din_hsync = 1'b0;
    ksz_sel = 2'b11;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    beat(1'b0, 2'b11, 16'd410, 8'd46);
    drain(1'b0, 2'b11);
  endtask

  initial begin
    test_reset();
    test_k3_lines();
    test_k5_k7();
    test_saturation();
    test_midframe_toggle();
    test_bypass();
    test_reset_midframe();
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout got running want finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/div_avg_mc.md
Name: div_avg_mc

Overview:
- Multi-channel, runtime-configurable successor to the 3x3-only averaging divider in the mean-filter datapath.
- Sits after the 2-D window summer; divides CH packed window sums by KSZ*KSZ with round-to-nearest and saturation.
- Emits DW-bit averages with vsync/hsync delayed by the pipeline latency.
- Kernel size is selectable per frame; an overflow status flag is added.

Parameters:
- CH, 3: number of channels packed on din/dout.
- SW, 16: bit width of each channel's input sum.
- DW, 8: bit width of each channel's output.
- SH, 20: reciprocal fractional shift.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- ksz_sel  in  2  kernel size select: 00=1 (bypass), 01=3, 10=5, 11=7.
- din_vsync  in  1  input frame-valid.
- din_hsync  in  1  input line-valid; qualifies din.
- din  in  CH*SW  packed sums; channel 0 in the LSBs.
- dout_vsync  out  1  din_vsync delayed 3 cycles.
- dout_hsync  out  1  din_hsync delayed 3 cycles.
- dout  out  CH*DW  packed averages; channel 0 in the LSBs.
- dout_ovf  out  1  high with a dout beat when any channel saturated.
- frame_ovf  out  1  sticky: any saturation in the current frame.

Behaviour:
- Reset: all outputs 0, all pipeline registers 0, active kernel = 3 (R=R3).
- ksz_sel capture: sampled only on a din_vsync rising edge (din_vsync=1 while its 1-cycle delayed copy=0). The captured value holds for the whole frame; changes mid-frame are ignored.
- Simultaneous vsync rise and hsync high: the newly captured ksz applies to that same beat.
- Reciprocal constants R (SH=20):
  - R1 = 2^20
  - R3 = 116508
  - R5 = 41943
  - R7 = 21400
- Pipeline, per channel, fixed latency 3 cycles, no stall:
  - S1: register din, hsync, vsync and the selected R.
  - S2: p = din * R, unsigned, SW+21 bits wide.
  - S3: q = (p + 2^(SH-1)) >> SH. If q > 2^DW-1, output 2^DW-1 and set that channel's sat bit; otherwise output q[DW-1:0].
- Bit-exact formula: the arithmetic above is the exact required result. For din <= 255*N it equals round(din/N).
- Output gating: dout = 0 and dout_ovf = 0 whenever dout_hsync = 0, regardless of din contents.
- Overflow flags:
  - dout_ovf = OR of the channel sat bits in S3, gated by hsync.
  - frame_ovf sets when dout_ovf = 1.
  - frame_ovf clears on a dout_vsync rising edge. If set and clear coincide, set wins.
- Bypass (ksz 1): dout = saturate(din), i.e. exact truncation-free passthrough up to 2^DW-1.
- Back-to-back beats and a continuously high hsync are sustained at one result per cycle.
- Reset mid-frame: outputs go to 0 asynchronously. After release, the active kernel is 3 until the next vsync rising edge.

Decomposition:
- Package div_avg_pkg:
  - the R1/R3/R5/R7 constants and SH
  - ksz_sel encoding localparams
  - function f_recip(ksz_sel) returning R
- Sub-module div_avg_lane: one channel's S2/S3 multiply, round and saturate. Generated CH times.
- The top holds the sync delay line, ksz capture, R register and flag logic.

Test Plan:
- ksz=3 (01), one channel. Beats 10, 28, 37, 410, then after a gap 46, 255, 630, 323 -> dout 1, 3, 4, 46, then 5, 28, 70, 36. hsync/vsync delayed exactly 3 cycles; dout = 0 between lines.
- ksz=5 frame with sums 37, 323, 6375; ksz=7 frame with sums 630, 12495 -> 1, 13, 255 and 13, 255. dout_ovf never asserts.
- Saturation, ksz=3: sum 65535 on ch1 only, ch0=2295 -> ch1=255, ch0=255. dout_ovf=1 on that beat only; frame_ovf stays 1 until the next dout_vsync rise, then 0.
- ksz_sel toggled 01->11 mid-frame -> current frame still divides by 9; the next frame divides by 49 (630 -> 13).
- Bypass ksz=00: sums 200 and 300 -> 200 and 255 with dout_ovf=1.
- Assert rst while hsync is active -> all outputs 0 immediately. After release, sum 410 with no new vsync edge -> 46 (kernel 3 default).
